// File: rtl/cache_plru_ctrl.sv
// ---------------------------------------------------------------------------
// cache_plru_ctrl
//
// Tree pseudo-LRU replacement controller for a set-associative cache. One
// tree of NUM_WAYS-1 bits per set is kept in a small array. Node 1 is the
// root, the children of node n are 2n and 2n+1, and bit n is stored at array
// bit n-1. A node value of 0 means the LRU side is the left subtree.
//
// After reset, or on a flush pulse, a sweep writes zero to every set, one set
// per cycle. No request is accepted until the sweep has finished.
//
// Fills choose a victim. The choice order is: the lowest invalid way, then
// the tree-walk way if it is unlocked, then the lowest unlocked way. The
// chosen way is promoted to MRU. Hits coming from stage 1 (update_en) promote
// update_way.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   flush_en          pulse: restart the clear sweep (drops stage-1 work)
//   ready             high once the sweep is done; requests accepted
//   fill_en/fill_set  victim request for a set
//   fill_valid        per-way valid bits, sampled with fill_en
//   fill_lock         per-way lock bits, sampled with fill_en
//   fill_way          victim way, registered, one cycle after fill_en
//   fill_way_valid    one-cycle strobe qualifying fill_way
//   access_en/_set    stage-0 lookup of a set (a fill in the same cycle wins)
//   update_en/_way    stage-1 hit: promote update_way of the looked-up set
// ---------------------------------------------------------------------------
module cache_plru_ctrl #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_en,
  output logic                ready,
  input  logic                fill_en,
  input  logic [SET_W-1:0]    fill_set,
  input  logic [NUM_WAYS-1:0] fill_valid,
  input  logic [NUM_WAYS-1:0] fill_lock,
  output logic [WAY_W-1:0]    fill_way,
  output logic                fill_way_valid,
  input  logic                access_en,
  input  logic [SET_W-1:0]    access_set,
  input  logic                update_en,
  input  logic [WAY_W-1:0]    update_way
);

  localparam int LVL = $clog2(NUM_WAYS);
  // A single-way cache has no tree bits. One dummy bit keeps the array legal.
  localparam int TW  = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  typedef enum logic {INIT, RUN} state_e;

  // Follow the LRU pointers from the root down to a leaf.
  function automatic logic [WAY_W-1:0] plru_walk(input logic [TW-1:0] t);
    int n;
    n = 1;
    for (int l = 0; l < LVL; l++) n = 2 * n + int'(t[n-1]);
    return WAY_W'(n - NUM_WAYS);
  endfunction

  // Point every node on the path to way w away from w.
  function automatic logic [TW-1:0] plru_promote(input logic [TW-1:0] t,
                                                 input logic [WAY_W-1:0] w);
    logic [TW-1:0] r;
    logic          b;
    int            n;
    r = t;
    n = 1;
    for (int l = 0; l < LVL; l++) begin
      b        = w[LVL-1-l];
      r[n-1]   = ~b;
      n        = 2 * n + int'(b);
    end
    return r;
  endfunction

  state_e             state_q;
  logic [SET_W-1:0]   cnt_q;
  logic               ready_q;
  logic               s1_fill_q;     // stage 1 holds a fill with a victim
  logic               s1_acc_q;      // stage 1 holds an access (may get a hit)
  logic [SET_W-1:0]   s1_set_q;
  logic [TW-1:0]      s1_flags_q;
  logic [WAY_W-1:0]   s1_way_q;
  logic [WAY_W-1:0]   fill_way_q;
  logic               fill_way_valid_q;
  logic               acc_prev_q;

  logic [TW-1:0]      mem_q [NUM_SETS];

  logic [SET_W-1:0]   sel_set;
  logic               cnt_last;
  logic               wr_en;
  logic [WAY_W-1:0]   wr_way;
  logic [TW-1:0]      wr_flags_d;
  logic [TW-1:0]      rd_flags_d;
  logic [WAY_W-1:0]   tree_way;
  logic               tree_ok;
  logic [WAY_W-1:0]   inv_way;
  logic               inv_any;
  logic [WAY_W-1:0]   unl_way;
  logic               unl_any;
  logic [WAY_W-1:0]   vic_way_d;
  logic               vic_found;

  assign sel_set  = fill_en ? fill_set : access_set;
  assign cnt_last = (cnt_q == SET_W'(NUM_SETS - 1));

  // Stage-1 write. A flush in the same cycle kills it.
  always_comb begin
    wr_way     = s1_fill_q ? s1_way_q : update_way;
    wr_flags_d = plru_promote(s1_flags_q, wr_way);
    wr_en      = (state_q == RUN) && !flush_en &&
                 (s1_fill_q || (s1_acc_q && update_en));
    // Bypass: a read of the set being written this cycle sees the new tree,
    // so back-to-back operations on one set never use stale state.
    rd_flags_d = (wr_en && (s1_set_q == sel_set)) ? wr_flags_d : mem_q[sel_set];
  end

  // Victim selection. It is resolved before the request is registered, so
  // fill_way comes straight from a flop one cycle after fill_en.
  always_comb begin
    tree_way = plru_walk(rd_flags_d);
    tree_ok  = 1'b0;
    inv_way  = '0;
    inv_any  = 1'b0;
    unl_way  = '0;
    unl_any  = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if ((WAY_W'(i) == tree_way) && !fill_lock[i]) tree_ok = 1'b1;
    end
    // Scanning downward leaves the lowest matching index as the result.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!fill_valid[i]) begin
        inv_way = WAY_W'(i);
        inv_any = 1'b1;
      end
      if (!fill_lock[i]) begin
        unl_way = WAY_W'(i);
        unl_any = 1'b1;
      end
    end
    vic_found = 1'b1;
    vic_way_d = '0;
    if (inv_any)       vic_way_d = inv_way;
    else if (tree_ok)  vic_way_d = tree_way;
    else if (unl_any)  vic_way_d = unl_way;
    else               vic_found = 1'b0;
  end

  // Sweep FSM, pipeline registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= INIT;
      cnt_q            <= '0;
      ready_q          <= 1'b0;
      s1_fill_q        <= 1'b0;
      s1_acc_q         <= 1'b0;
      s1_set_q         <= '0;
      s1_flags_q       <= '0;
      s1_way_q         <= '0;
      fill_way_q       <= '0;
      fill_way_valid_q <= 1'b0;
      acc_prev_q       <= 1'b0;
    end else begin
      acc_prev_q       <= access_en;
      fill_way_valid_q <= 1'b0;
      s1_fill_q        <= 1'b0;
      s1_acc_q         <= 1'b0;
      case (state_q)
        INIT: begin
          if (flush_en) begin
            cnt_q <= '0;
          end else if (cnt_last) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + SET_W'(1);
          end
        end
        RUN: begin
          if (flush_en) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            s1_fill_q  <= fill_en & vic_found;
            s1_acc_q   <= ~fill_en & access_en;
            s1_set_q   <= sel_set;
            s1_flags_q <= rd_flags_d;
            s1_way_q   <= vic_way_d;
            if (fill_en) begin
              fill_way_q       <= vic_found ? vic_way_d : '0;
              fill_way_valid_q <= vic_found;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Tree storage. The sweep owns the write port while it runs.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem_q[cnt_q] <= '0;
    else if (wr_en)      mem_q[s1_set_q] <= wr_flags_d;
  end

  assign ready          = ready_q;
  assign fill_way       = fill_way_q;
  assign fill_way_valid = fill_way_valid_q;

  // A hit update must follow an access lookup from the previous cycle.
  assert property (@(posedge clk) disable iff (reset)
                   ((state_q == RUN) && update_en) |-> acc_prev_q);

endmodule

// File: tb/tb_cache_plru_ctrl.sv
module tb_cache_plru_ctrl;

  logic clk;
  logic reset;

  // DUT a: 4 sets x 4 ways
  logic       a_flush, a_ready, a_fill_en, a_fill_way_valid;
  logic       a_access_en, a_update_en;
  logic [1:0] a_fill_set, a_access_set, a_fill_way, a_update_way;
  logic [3:0] a_fill_valid, a_fill_lock;

  // DUT b: 4 sets x 16 ways
  logic        b_flush, b_ready, b_fill_en, b_fill_way_valid;
  logic        b_access_en, b_update_en;
  logic [1:0]  b_fill_set, b_access_set;
  logic [3:0]  b_fill_way, b_update_way;
  logic [15:0] b_fill_valid, b_fill_lock;

  int total;
  int bad;

  cache_plru_ctrl #(.NUM_SETS(4), .NUM_WAYS(4)) dut_a (
    .clk(clk), .reset(reset), .flush_en(a_flush), .ready(a_ready),
    .fill_en(a_fill_en), .fill_set(a_fill_set), .fill_valid(a_fill_valid),
    .fill_lock(a_fill_lock), .fill_way(a_fill_way),
    .fill_way_valid(a_fill_way_valid), .access_en(a_access_en),
    .access_set(a_access_set), .update_en(a_update_en),
    .update_way(a_update_way)
  );

  cache_plru_ctrl #(.NUM_SETS(4), .NUM_WAYS(16)) dut_b (
    .clk(clk), .reset(reset), .flush_en(b_flush), .ready(b_ready),
    .fill_en(b_fill_en), .fill_set(b_fill_set), .fill_valid(b_fill_valid),
    .fill_lock(b_fill_lock), .fill_way(b_fill_way),
    .fill_way_valid(b_fill_way_valid), .access_en(b_access_en),
    .access_set(b_access_set), .update_en(b_update_en),
    .update_way(b_update_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_fill(input logic [1:0] set, input logic [3:0] valid,
                        input logic [3:0] lock);
    a_fill_en    = 1'b1;
    a_fill_set   = set;
    a_fill_valid = valid;
    a_fill_lock  = lock;
  endtask

  task automatic a_fill_chk(input string tag, input logic [1:0] set,
                            input logic [3:0] valid, input logic [3:0] lock,
                            input int exp_way, input int exp_wv);
    a_fill(set, valid, lock);
    tick();
    check({tag, "_wv"}, int'(a_fill_way_valid), exp_wv);
    check({tag, "_way"}, int'(a_fill_way), exp_way);
  endtask

  int seq2 [5]  = '{0, 2, 1, 3, 0};
  int seq16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [15:0] seen;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    a_flush = 0; a_fill_en = 0; a_fill_set = 0; a_fill_valid = 4'hf;
    a_fill_lock = 0; a_access_en = 0; a_access_set = 0; a_update_en = 0;
    a_update_way = 0;
    b_flush = 0; b_fill_en = 0; b_fill_set = 0; b_fill_valid = 16'hffff;
    b_fill_lock = 0; b_access_en = 0; b_access_set = 0; b_update_en = 0;
    b_update_way = 0;

    repeat (2) tick();
    check("rst_ready", int'(a_ready), 0);
    check("rst_way", int'(a_fill_way), 0);
    check("rst_wv", int'(a_fill_way_valid), 0);
    check("rst_ready16", int'(b_ready), 0);
    reset = 1'b0;

    // Sweep: a fill held high during INIT is ignored; ready after 4 cycles.
    a_fill(2'd0, 4'hf, 4'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("sweep_wv", int'(a_fill_way_valid), 0);
      check("sweep_ready", int'(a_ready), int'(k == 4));
      check("sweep_ready16", int'(b_ready), int'(k == 4));
    end

    // Back-to-back fills of set 0 walk the tree: 0,2,1,3,0.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("seq_wv", int'(a_fill_way_valid), 1);
      check("seq_way", int'(a_fill_way), seq2[i]);
    end
    a_fill_en = 1'b0;
    tick();
    check("idle_wv", int'(a_fill_way_valid), 0);

    // Invalid ways take priority over the tree.
    a_fill_chk("inv1", 2'd2, 4'b1011, 4'h0, 2, 1);
    a_fill_chk("inv_next", 2'd2, 4'hf, 4'h0, 0, 1);
    a_fill_chk("inv2", 2'd2, 4'b1011, 4'h0, 2, 1);
    a_fill_chk("inv_after", 2'd2, 4'hf, 4'h0, 1, 1);

    // Locks: tree way locked, then all locked, then unlocked again.
    a_fill_chk("lock1", 2'd3, 4'hf, 4'b0001, 1, 1);
    a_fill_chk("lock_all", 2'd1, 4'hf, 4'hf, 0, 0);
    a_fill_chk("lock_after", 2'd1, 4'hf, 4'h0, 0, 1);
    a_fill_en = 1'b0;

    // Flush in RUN: ready low for 4 cycles.
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("flush_ready", int'(a_ready), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("flush_sweep_ready", int'(a_ready), int'(k == 4));
    end

    // Access then hit update of way 0, then fill of set 1 -> way 2.
    a_access_en = 1'b1; a_access_set = 2'd1;
    tick();
    check("acc_wv", int'(a_fill_way_valid), 0);
    a_access_en = 1'b0; a_update_en = 1'b1; a_update_way = 2'd0;
    tick();
    a_update_en = 1'b0;
    a_fill_chk("upd_fill", 2'd1, 4'hf, 4'h0, 2, 1);
    // Fill and access together: fill wins; the following update is ignored.
    a_access_en = 1'b1; a_access_set = 2'd1;
    a_fill_chk("both_fill", 2'd1, 4'hf, 4'h0, 1, 1);
    a_fill_en = 1'b0; a_access_en = 1'b0;
    a_update_en = 1'b1; a_update_way = 2'd3;
    tick();
    check("ign_upd_wv", int'(a_fill_way_valid), 0);
    a_update_en = 1'b0;
    a_fill_chk("ign_upd_fill", 2'd1, 4'hf, 4'h0, 3, 1);

    // Previously dirty sets read back cleared after the flush.
    a_fill_chk("clr_set0", 2'd0, 4'hf, 4'h0, 0, 1);
    a_fill_chk("clr_set2", 2'd2, 4'hf, 4'h0, 0, 1);
    a_fill_chk("clr_set3", 2'd3, 4'hf, 4'h0, 0, 1);
    a_fill_en = 1'b0;
    tick();

    // 16 ways: 16 back-to-back fills return every way once.
    seen = '0;
    b_fill_en = 1'b1; b_fill_set = 2'd0; b_fill_valid = 16'hffff;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("w16_wv", int'(b_fill_way_valid), 1);
      check("w16_way", int'(b_fill_way), seq16[i]);
      seen[b_fill_way] = 1'b1;
    end
    check("w16_all_seen", int'(seen), 32'hffff);
    b_fill_valid = 16'hdfff;
    tick();
    check("w16_inv13", int'(b_fill_way), 13);

    // Flush while a fill sits in stage 1.
    b_fill_valid = 16'hffff; b_fill_set = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w16_pre_flush", int'(b_fill_way), seq16[i]);
    end
    b_fill_en = 1'b0;
    b_flush   = 1'b1;
    tick();
    b_flush = 1'b0;
    check("w16_flush_ready", int'(b_ready), 0);
    check("w16_flush_wv", int'(b_fill_way_valid), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("w16_sweep_ready", int'(b_ready), int'(k == 4));
    end
    b_fill_en = 1'b1; b_fill_set = 2'd1;
    tick();
    check("w16_clr_set1", int'(b_fill_way), 0);
    b_fill_set = 2'd0;
    tick();
    check("w16_clr_set0", int'(b_fill_way), 0);
    check("w16_clr_wv", int'(b_fill_way_valid), 1);
    b_fill_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_plru_ctrl.md
Name: cache_plru_ctrl

Overview:
Parametrised pseudo-LRU replacement controller for set-associative caches. It supports up to 16 ways, and performs a hardware clear of all LRU state after reset or on a flush request. Victim selection prefers invalid ways and skips locked ways. Back-to-back operations to the same set are forwarded, so they never read stale state. It sits beside the tag/data arrays in the L1/L2 cache pipelines and answers fill requests one cycle after they are issued.

Parameters:
NUM_SETS, 64, number of sets; power of 2, >=1; SET_W = max(1, clog2(NUM_SETS)).
NUM_WAYS, 4, associativity; 1, 2, 4, 8 or 16; WAY_W = max(1, clog2(NUM_WAYS)).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high.
flush_en  in  1  pulse: restart the state clear sweep.
ready  out  1  high when the sweep is complete and requests are accepted.
fill_en  in  1  request a victim way for fill_set.
fill_set  in  SET_W  set to fill.
fill_valid  in  NUM_WAYS  per-way valid bits of fill_set, sampled with fill_en.
fill_lock  in  NUM_WAYS  per-way lock bits, sampled with fill_en.
fill_way  out  WAY_W  chosen victim way, one cycle after fill_en.
fill_way_valid  out  1  one-cycle strobe qualifying fill_way.
access_en  in  1  stage-0 lookup of access_set.
access_set  in  SET_W  accessed set.
update_en  in  1  stage-1 hit: promote update_way to MRU.
update_way  in  WAY_W  hit way.

Behaviour:
- State storage:
  - Per set: NUM_WAYS-1 tree bits, heap-indexed. Node 1 is the root; the children of node n are 2n and 2n+1.
  - A bit value of 0 means the LRU is on the left; 1 means the LRU is on the right.
  - For NUM_WAYS = 1, there are no bits; fill_way is always 0.
- Reset:
  - ready=0, fill_way=0, fill_way_valid=0. All pipeline registers are cleared.
  - Sweep FSM states: INIT, RUN.
- INIT:
  - A set counter runs from 0 to NUM_SETS-1, writing all-zero flags, one set per cycle.
  - The FSM moves to RUN after the last write, and ready=1 from the following cycle. Total: NUM_SETS cycles after reset deassertion.
  - In INIT, fill_en, access_en and update_en are ignored, and fill_way_valid stays 0.
- flush_en:
  - In RUN: any in-flight stage-1 result is dropped (no write), then the FSM enters INIT with counter=0.
  - In INIT: the counter restarts at 0.
  - Reset asserted mid-sweep also restarts the sweep.
- Pipeline:
  - Stage 0 reads the flags of sel_set, where sel_set = fill_set if fill_en, else access_set.
  - If fill_en and access_en are asserted together, fill wins and the access is dropped.
  - Stage 1 holds the registered set, the was_fill flag, the valid mask and the lock mask.
- Victim selection, stage 1, on fill:
  - (1) If any way is invalid: the lowest-index invalid way.
  - (2) Else, the tree-walk PLRU way, if it is unlocked.
  - (3) Else, the lowest-index unlocked way.
  - (4) If all ways are locked: fill_way=0, fill_way_valid=0, and no state update.
  - In cases (1)-(3): fill_way_valid=1, and the chosen way is promoted to MRU.
- MRU promotion:
  - Every node on the root-to-leaf path is set to point away from the way. All other bits are unchanged.
  - Sources: the fill victim if was_fill; else update_way if update_en.
  - update_en in the cycle after a fill is ignored.
  - update_en without a preceding access_en is illegal; a simulation assertion flags it.
- Forwarding:
  - A stage-1 write to set S in cycle N must be visible to a stage-0 read of S in cycle N+1.
  - Same-cycle read/write of S returns the new data (internal bypass mux).
  - Consecutive fills to one set must therefore yield distinct ways when all ways are valid and unlocked.
- Outputs: fill_way and fill_way_valid are registered.
- No throughput stalls: one request per cycle is accepted in RUN.

Test Plan:
1. NUM_SETS=4: release reset → ready rises exactly 4 cycles later. flush_en in RUN → ready=0 for 4 cycles, then every set reads all-zero flags.
2. NUM_WAYS=4, all ways valid and unlocked: fills to set 0 on consecutive cycles → fill_way sequence 0, 2, 1, 3, 0 (this also exercises forwarding).
3. fill_valid=4'b1011 → fill_way=2 regardless of tree state. Repeating the fill with all ways valid → fill_way follows the updated tree (the next way is not 2).
4. Fresh state, fill_lock=4'b0001 → fill_way=1. fill_lock=4'b1111 → fill_way_valid=0, and a following unlocked fill still returns 0.
5. access_en to set 1 with update_en, update_way=0 the next cycle; then fill set 1 → fill_way=2. Fill and access asserted together → the access update is ignored.
6. NUM_WAYS=16: 16 back-to-back fills, all valid → each way is returned exactly once. flush_en mid-sequence → ready drops, and no write from the dropped stage 1 occurs.
